multicycle_control: RTL and testbench

Parametrised control unit for the non-pipelined processor. It decodes the 32-bit instruction word into datapath controls: register write, ALU operand and op select, memory write, writeback select, branch/jump and overflow status writes. It adds a state machine that sequences multi-cycle mul/div operations through the multdiv unit, stalling the PC until the result is ready or a timeout expires. It sits between imem and the regfile/ALU/dmem/multdiv datapath.

---
 rtl/multicycle_control.sv | 177 +++++++++++++++++
 tb/tb_multicycle_control.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Control unit for the non-pipelined processor: combinational instruction decode
// plus a two-state sequencer that stalls the PC while the multdiv unit works.
module multicycle_control #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int STATUS_REG = 30,
    parameter int RA_REG     = 31,
    parameter int MD_TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           insn,
    input  logic                  alu_overflow,
    input  logic                  alu_neq,
    input  logic                  alu_lt,
    input  logic                  md_ready,
    input  logic                  md_exception,
    output logic                  rwe,
    output logic [REG_ADDR_W-1:0] wb_reg,
    output logic                  rdst,
    output logic                  alu_in_b,
    output logic [4:0]            alu_op,
    output logic                  dmwe,
    output logic [1:0]            rwd_sel,
    output logic                  br,
    output logic                  jp,
    output logic                  jr,
    output logic                  set_status,
    output logic [DATA_WIDTH-1:0] status_value,
    output logic                  ctrl_mult,
    output logic                  ctrl_div,
    output logic                  pc_stall
);
    localparam int CNT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MD_TIMEOUT - 1);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] FN_ADD  = 5'b00000;
    localparam logic [4:0] FN_SUB  = 5'b00001;
    localparam logic [4:0] FN_MUL  = 5'b00110;
    localparam logic [4:0] FN_DIV  = 5'b00111;

    typedef enum logic {RUN, MD_WAIT} state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      count, count_next;
    logic [4:0]            opcode, fn;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_md;
    logic [2:0]            code;
    logic                  unused_bits;

    assign opcode      = insn[31:27];
    assign fn          = insn[6:2];
    assign rd          = REG_ADDR_W'(insn[26:22]);
    assign is_md       = (opcode == OP_R) && (fn == FN_MUL || fn == FN_DIV);
    assign unused_bits = ^{insn[21:7], insn[1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next   = state;
        count_next   = count;
        rwe          = 1'b0;
        wb_reg       = rd;
        rdst         = 1'b0;
        alu_in_b     = 1'b0;
        alu_op       = (opcode == OP_R) ? fn :
                       ((opcode == OP_BNE || opcode == OP_BLT) ? 5'b00001 : 5'b00000);
        dmwe         = 1'b0;
        rwd_sel      = 2'd0;
        br           = 1'b0;
        jp           = 1'b0;
        jr           = 1'b0;
        set_status   = 1'b0;
        status_value = '0;
        ctrl_mult    = 1'b0;
        ctrl_div     = 1'b0;
        pc_stall     = 1'b0;
        code         = 3'd0;
        if (!reset) begin
            unique case (state)
                RUN: begin
                    if (is_md) begin
                        ctrl_mult  = (fn == FN_MUL);
                        ctrl_div   = (fn == FN_DIV);
                        pc_stall   = 1'b1;
                        count_next = '0;
                        state_next = MD_WAIT;
                    end else begin
                        case (opcode)
                            OP_R: begin
                                rwe = (rd != '0);
                                if (alu_overflow && fn == FN_ADD) code = 3'd1;
                                if (alu_overflow && fn == FN_SUB) code = 3'd3;
                            end
                            OP_ADDI: begin
                                alu_in_b = 1'b1;
                                rwe      = (rd != '0);
                                if (alu_overflow) code = 3'd2;
                            end
                            OP_SW: begin
                                alu_in_b = 1'b1;
                                rdst     = 1'b1;
                                dmwe     = 1'b1;
                            end
                            OP_LW: begin
                                alu_in_b = 1'b1;
                                rwe      = (rd != '0);
                                rwd_sel  = 2'd1;
                            end
                            OP_J: jp = 1'b1;
                            OP_JAL: begin
                                jp      = 1'b1;
                                wb_reg  = REG_ADDR_W'(RA_REG);
                                rwe     = (RA_REG != 0);
                                rwd_sel = 2'd2;
                            end
                            OP_JR: begin
                                rdst = 1'b1;
                                jr   = 1'b1;
                            end
                            OP_BNE: begin
                                rdst = 1'b1;
                                br   = alu_neq;
                            end
                            OP_BLT: begin
                                rdst = 1'b1;
                                br   = alu_lt;
                            end
                            default: ;
                        endcase
                    end
                end
                MD_WAIT: begin
                    // A real result beats the timeout when both land on the same cycle.
                    if (md_ready || count == CNT_MAX) begin
                        state_next = RUN;
                        if (md_ready && !md_exception) begin
                            rwe     = (rd != '0);
                            rwd_sel = 2'd3;
                        end else begin
                            code = (fn == FN_DIV) ? 3'd5 : 3'd4;
                        end
                    end else begin
                        pc_stall   = 1'b1;
                        count_next = count + CNT_W'(1);
                    end
                end
                default: state_next = RUN;
            endcase
            if (code != 3'd0) begin
                set_status   = 1'b1;
                rwe          = 1'b1;
                wb_reg       = REG_ADDR_W'(STATUS_REG);
                rwd_sel      = 2'd0;
                status_value = DATA_WIDTH'(code);
            end
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: decode table, randomized decode against a rule
// model, and cycle-by-cycle mul/div sequences including timeout and reset abort.
module tb_multicycle_control;
    localparam int MD_TO = 64;

    logic        clock, reset;
    logic [31:0] insn;
    logic        alu_overflow, alu_neq, alu_lt, md_ready, md_exception;
    logic        rwe, rdst, alu_in_b, dmwe, br, jp, jr, set_status;
    logic        ctrl_mult, ctrl_div, pc_stall;
    logic [4:0]  wb_reg, alu_op;
    logic [1:0]  rwd_sel;
    logic [31:0] status_value;

    int checks = 0;
    int failures = 0;

    multicycle_control #(.MD_TIMEOUT(MD_TO)) dut (
        .clock(clock), .reset(reset), .insn(insn), .alu_overflow(alu_overflow),
        .alu_neq(alu_neq), .alu_lt(alu_lt), .md_ready(md_ready),
        .md_exception(md_exception), .rwe(rwe), .wb_reg(wb_reg), .rdst(rdst),
        .alu_in_b(alu_in_b), .alu_op(alu_op), .dmwe(dmwe), .rwd_sel(rwd_sel),
        .br(br), .jp(jp), .jr(jr), .set_status(set_status),
        .status_value(status_value), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
        .pc_stall(pc_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        rwe;
        logic [4:0]  wb_reg;
        logic        rdst, alu_in_b;
        logic [4:0]  alu_op;
        logic        dmwe;
        logic [1:0]  rwd_sel;
        logic        br, jp, jr, set_status;
        logic [31:0] status_value;
        logic        ctrl_mult, ctrl_div, pc_stall;
    } outs_t;

    typedef struct {
        logic [31:0] insn;
        logic        ovf, neq, lt;
        outs_t       exp;
    } vec_t;

    function automatic outs_t act();
        outs_t a;
        a.rwe = rwe; a.wb_reg = wb_reg; a.rdst = rdst; a.alu_in_b = alu_in_b;
        a.alu_op = alu_op; a.dmwe = dmwe; a.rwd_sel = rwd_sel; a.br = br;
        a.jp = jp; a.jr = jr; a.set_status = set_status;
        a.status_value = status_value; a.ctrl_mult = ctrl_mult;
        a.ctrl_div = ctrl_div; a.pc_stall = pc_stall;
        return a;
    endfunction

    function automatic outs_t o(logic w, int wb, logic rd_b, logic inb, int op,
                                logic dw, int rs, logic b, logic j, logic r,
                                logic ss, int sv);
        outs_t e = '0;
        e.rwe = w; e.wb_reg = 5'(wb); e.rdst = rd_b; e.alu_in_b = inb;
        e.alu_op = 5'(op); e.dmwe = dw; e.rwd_sel = 2'(rs); e.br = b; e.jp = j;
        e.jr = r; e.set_status = ss; e.status_value = 32'(sv);
        return e;
    endfunction

    function automatic logic [31:0] r_insn(int rd, int rs, int rt, int fn);
        return {5'b0, 5'(rd), 5'(rs), 5'(rt), 5'b0, 5'(fn), 2'b0};
    endfunction

    function automatic logic [31:0] i_insn(int op, int rd, int rs, int imm);
        return {5'(op), 5'(rd), 5'(rs), 17'(imm)};
    endfunction

    // Rule-level model of single-cycle decode in RUN.
    function automatic outs_t ref_run(logic [31:0] in, logic ovf, logic neq, logic lt);
        outs_t e = '0;
        int op = int'(in[31:27]);
        int fn = int'(in[6:2]);
        bit is_r = (op == 0), is_addi = (op == 5), is_sw = (op == 7), is_lw = (op == 8);
        bit is_j = (op == 1), is_bne = (op == 2), is_jal = (op == 3), is_jr = (op == 4);
        bit is_blt = (op == 6);
        int code;
        e.alu_op   = is_r ? 5'(fn) : ((is_bne || is_blt) ? 5'd1 : 5'd0);
        e.wb_reg   = is_jal ? 5'd31 : in[26:22];
        e.rwe      = (is_r || is_addi || is_lw || is_jal) && (e.wb_reg != 0);
        e.rdst     = is_sw || is_bne || is_blt || is_jr;
        e.alu_in_b = is_addi || is_sw || is_lw;
        e.dmwe     = is_sw;
        e.rwd_sel  = is_lw ? 2'd1 : (is_jal ? 2'd2 : 2'd0);
        e.br       = (is_bne && neq) || (is_blt && lt);
        e.jp       = is_j || is_jal;
        e.jr       = is_jr;
        code = !ovf ? 0 : (is_r && fn == 0) ? 1 : is_addi ? 2 : (is_r && fn == 1) ? 3 : 0;
        if (code != 0) begin
            e.set_status = 1'b1; e.status_value = 32'(code);
            e.rwe = 1'b1; e.wb_reg = 5'd30; e.rwd_sel = 2'd0;
        end
        return e;
    endfunction

    task automatic chk(string name, outs_t e, outs_t a);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, a, e);
        end
    endtask

    // One mul/div from start pulse to completion; lat=0 never raises md_ready,
    // abort_at>=0 asserts reset on that cycle.
    task automatic run_md(string tag, logic div, int rd, int lat, logic exc, int abort_at);
        outs_t e, a;
        bit done = 0;
        for (int k = 0; k <= MD_TO && !done; k++) begin
            insn = r_insn(rd, 1, 2, div ? 7 : 6);
            md_ready = (lat != 0 && k == lat);
            md_exception = md_ready ? exc : 1'($urandom);
            reset = (k == abort_at);
            alu_overflow = 1'($urandom); alu_neq = 1'($urandom); alu_lt = 1'($urandom);
            e = '0;
            e.alu_op = div ? 5'd7 : 5'd6;
            e.wb_reg = 5'(rd);
            if (k == abort_at) begin
                done = 1;
            end else if (k == 0) begin
                e.ctrl_mult = !div; e.ctrl_div = div; e.pc_stall = 1'b1;
            end else if (md_ready || k == MD_TO) begin
                done = 1;
                if (md_ready && !exc) begin
                    e.rwe = (rd != 0); e.rwd_sel = 2'd3;
                end else begin
                    e.set_status = 1'b1; e.status_value = div ? 32'd5 : 32'd4;
                    e.rwe = 1'b1; e.wb_reg = 5'd30;
                end
            end else begin
                e.pc_stall = 1'b1;
            end
            @(negedge clock);
            a = act();
            if (reset) begin a.wb_reg = '0; e.wb_reg = '0; end
            chk($sformatf("%s_k%0d", tag, k), e, a);
            @(posedge clock); #1;
        end
        reset = 1'b0;
        md_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[$];
        outs_t e, a;

        vecs.push_back(vec_t'{r_insn(3, 1, 2, 0), 1'b1, 1'b0, 1'b0, o(1, 30, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)});
        vecs.push_back(vec_t'{r_insn(3, 1, 2, 1), 1'b1, 1'b0, 1'b0, o(1, 30, 0, 0, 1, 0, 0, 0, 0, 0, 1, 3)});
        vecs.push_back(vec_t'{i_insn(5, 3, 1, 7), 1'b1, 1'b0, 1'b0, o(1, 30, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2)});
        vecs.push_back(vec_t'{r_insn(0, 1, 2, 0), 1'b0, 1'b0, 1'b0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back(vec_t'{i_insn(8, 4, 1, 0), 1'b0, 1'b0, 1'b0, o(1, 4, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0)});
        vecs.push_back(vec_t'{i_insn(7, 4, 1, 0), 1'b0, 1'b0, 1'b0, o(0, 4, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0)});
        vecs.push_back(vec_t'{i_insn(2, 4, 1, 9), 1'b0, 1'b1, 1'b0, o(0, 4, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back(vec_t'{i_insn(6, 4, 1, 9), 1'b0, 1'b1, 1'b0, o(0, 4, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back(vec_t'{i_insn(6, 4, 1, 9), 1'b0, 1'b0, 1'b1, o(0, 4, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back(vec_t'{i_insn(3, 12, 0, 5), 1'b0, 1'b0, 1'b0, o(1, 31, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0)});
        vecs.push_back(vec_t'{i_insn(1, 0, 0, 64), 1'b0, 1'b0, 1'b0, o(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)});
        vecs.push_back(vec_t'{i_insn(4, 9, 0, 0), 1'b0, 1'b0, 1'b0, o(0, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0)});
        vecs.push_back(vec_t'{i_insn(31, 6, 1, 0), 1'b1, 1'b1, 1'b1, o(0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back(vec_t'{r_insn(5, 1, 2, 2), 1'b1, 1'b0, 1'b0, o(1, 5, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back(vec_t'{i_insn(5, 0, 1, 3), 1'b0, 1'b0, 1'b0, o(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)});

        // Reset: everything quiet, alu_op still follows insn.
        reset = 1'b1; insn = r_insn(3, 1, 2, 1); alu_overflow = 1'b1;
        alu_neq = 1'b1; alu_lt = 1'b1; md_ready = 1'b1; md_exception = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        e = '0; e.alu_op = 5'd1;
        a = act(); a.wb_reg = '0;
        chk("reset_outputs", e, a);
        @(posedge clock); #1;
        reset = 1'b0; md_ready = 1'b0; md_exception = 1'b0;

        foreach (vecs[i]) begin
            insn = vecs[i].insn; alu_overflow = vecs[i].ovf;
            alu_neq = vecs[i].neq; alu_lt = vecs[i].lt;
            @(negedge clock);
            chk($sformatf("table_%0d", i), vecs[i].exp, act());
            @(posedge clock); #1;
        end

        run_md("mul_lat16", 1'b0, 5, 16, 1'b0, -1);
        run_md("div_exc", 1'b1, 8, 5, 1'b1, -1);
        run_md("div_timeout", 1'b1, 8, 0, 1'b0, -1);
        run_md("mul_ready_at_timeout", 1'b0, 11, MD_TO, 1'b0, -1);
        run_md("mul_rd0", 1'b0, 0, 3, 1'b0, -1);
        run_md("mul_abort", 1'b0, 5, 0, 1'b0, 4);
        run_md("mul_after_abort", 1'b0, 5, 2, 1'b0, -1);
        for (int n = 0; n < 6; n++)
            run_md($sformatf("md_rand%0d", n), 1'($urandom), int'($urandom_range(0, 31)),
                   int'($urandom_range(1, 20)), 1'($urandom), -1);

        for (int n = 0; n < 200; n++) begin
            int ops[10] = '{0, 5, 7, 8, 1, 2, 3, 4, 6, 0};
            logic [31:0] w = $urandom;
            ops[9] = int'($urandom_range(9, 31));
            w[31:27] = 5'(ops[$urandom_range(0, 9)]);
            if (w[31:27] == 5'd0 && w[6:3] == 4'b0011) w[4] = 1'b0;
            insn = w;
            alu_overflow = 1'($urandom); alu_neq = 1'($urandom); alu_lt = 1'($urandom);
            md_ready = 1'($urandom); md_exception = 1'($urandom);
            @(negedge clock);
            chk($sformatf("rand_%0d_insn_%h", n, w), ref_run(w, alu_overflow, alu_neq, alu_lt), act());
            @(posedge clock); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
